// File: rtl/syscall_print_unit_pkg.sv
// Shared syscall definitions: service codes, register numbers, FSM state
// encoding and the character helper used by the print unit.
package syscall_print_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  // Same register numbers the hazard unit compares against for the syscall stall.
  localparam logic [4:0] REG_V0 = 5'd2;
  localparam logic [4:0] REG_A0 = 5'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STR_REQ  = 3'd1,
    ST_STR_WAIT = 3'd2,
    ST_EMIT     = 3'd3,
    ST_INT_CONV = 3'd4,
    ST_DONE     = 3'd5,
    ST_HALT     = 3'd6
  } st_e;

  typedef enum logic [1:0] {
    K_CHAR = 2'd0,
    K_STR  = 2'd1,
    K_INT  = 2'd2
  } kind_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

endpackage

// File: rtl/syscall_print_unit_if.sv
// Pipeline, memory and console signals of the syscall print unit, plus a
// debug view of the FSM state.
interface syscall_print_unit_if #(parameter int ADDR_W = 32);
  import syscall_print_unit_pkg::*;

  // char_valid/char_ready: a character moves on a cycle where both are high;
  // once char_valid rises it stays high with char_data frozen until that cycle.
  logic              syscall_valid;
  logic [31:0]       v0;
  logic [31:0]       a0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              sys_busy;
  logic              sys_done;
  logic              halted;
  st_e               state;

  modport slave (
    input  syscall_valid, v0, a0, mem_rdata, char_ready,
    output mem_req, mem_addr, char_valid, char_data, sys_busy, sys_done, halted, state
  );

  modport master (
    output syscall_valid, v0, a0, mem_rdata, char_ready,
    input  mem_req, mem_addr, char_valid, char_data, sys_busy, sys_done, halted, state
  );

endinterface

// File: rtl/syscall_print_unit_bin2dec_serial.sv
// Iterative double-dabble converter (32-bit binary to 10 BCD digits), present
// only when SYSCALL_PRINT_INT_EN is defined; done pulses 32 cycles after start.
`ifdef SYSCALL_PRINT_INT_EN
module bin2dec_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] bin;
  logic [4:0]  cnt;
  logic        busy;
  logic [71:0] step_start;
  logic [71:0] step_run;

  function automatic logic [71:0] dd_step(input logic [39:0] b, input logic [31:0] v);
    logic [39:0] adj;
    adj = b;
    for (int i = 0; i < 10; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj, v} << 1;
  endfunction

  // The first shift happens on the start edge so the 32nd lands 31 edges later.
  assign step_start = dd_step(40'd0, value);
  assign step_run   = dd_step(bcd, bin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {bcd, bin} <= step_start;
        cnt        <= 5'd1;
        busy       <= 1'b1;
      end else if (busy) begin
        {bcd, bin} <= step_run;
        cnt        <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/syscall_print_unit.sv
// Output-syscall service unit beside decode: print_char, print_string, exit,
// and print_int when SYSCALL_PRINT_INT_EN is defined.
module syscall_print_unit
  import syscall_print_unit_pkg::*;
#(
  parameter int MAX_STR_LEN = 256,
  parameter int ADDR_W      = 32
) (
  input  logic clk,
  input  logic reset,
  syscall_print_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  st_e               state, state_n;
  kind_e             kind, kind_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [7:0]        char_q, char_n;

`ifdef SYSCALL_PRINT_INT_EN
  logic        neg, neg_n;
  logic [3:0]  dig_idx, dig_idx_n;
  logic        dig_left, dig_left_n;
  logic        conv_start;
  logic        conv_done;
  logic [39:0] conv_bcd;
  logic [31:0] conv_mag;
  logic [3:0]  lead;

  // Magnitude as unsigned so the most negative value converts correctly.
  assign conv_mag = bus.a0[31] ? (32'd0 - bus.a0) : bus.a0;

  bin2dec_serial u_bin2dec (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (conv_mag),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (conv_bcd[i*4 +: 4] != 4'd0) lead = 4'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      kind     <= K_CHAR;
      addr     <= '0;
      count    <= '0;
      char_q   <= '0;
`ifdef SYSCALL_PRINT_INT_EN
      neg      <= 1'b0;
      dig_idx  <= '0;
      dig_left <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      kind     <= kind_n;
      addr     <= addr_n;
      count    <= count_n;
      char_q   <= char_n;
`ifdef SYSCALL_PRINT_INT_EN
      neg      <= neg_n;
      dig_idx  <= dig_idx_n;
      dig_left <= dig_left_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    kind_n  = kind;
    addr_n  = addr;
    count_n = count;
    char_n  = char_q;
`ifdef SYSCALL_PRINT_INT_EN
    neg_n      = neg;
    dig_idx_n  = dig_idx;
    dig_left_n = dig_left;
    conv_start = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.syscall_valid) begin
          if (bus.v0 == SYS_PRINT_CHAR) begin
            kind_n  = K_CHAR;
            char_n  = bus.a0[7:0];
            state_n = ST_EMIT;
          end else if (bus.v0 == SYS_PRINT_STR) begin
            kind_n  = K_STR;
            addr_n  = bus.a0[ADDR_W-1:0];
            count_n = '0;
            state_n = ST_STR_REQ;
          end else if (bus.v0 == SYS_EXIT) begin
            state_n = ST_HALT;
`ifdef SYSCALL_PRINT_INT_EN
          end else if (bus.v0 == SYS_PRINT_INT) begin
            kind_n     = K_INT;
            neg_n      = bus.a0[31];
            conv_start = 1'b1;
            state_n    = ST_INT_CONV;
`endif
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_STR_REQ:  state_n = ST_STR_WAIT;
      ST_STR_WAIT: begin
        if (bus.mem_rdata == 8'h00) begin
          state_n = ST_DONE;
        end else begin
          char_n  = bus.mem_rdata;
          state_n = ST_EMIT;
        end
      end
`ifdef SYSCALL_PRINT_INT_EN
      ST_INT_CONV: begin
        if (conv_done) begin
          state_n    = ST_EMIT;
          dig_left_n = 1'b1;
          if (neg) begin
            char_n    = 8'h2d;
            dig_idx_n = lead;
          end else begin
            char_n = ascii_digit(conv_bcd[{lead, 2'b00} +: 4]);
            if (lead == 4'd0) dig_left_n = 1'b0;
            else              dig_idx_n  = lead - 4'd1;
          end
        end
      end
`endif
      ST_EMIT: begin
        if (bus.char_ready) begin
          case (kind)
            K_STR: begin
              addr_n  = addr + ADDR_W'(1);
              count_n = count + CNT_W'(1);
              state_n = (count_n == CNT_W'(MAX_STR_LEN)) ? ST_DONE : ST_STR_REQ;
            end
`ifdef SYSCALL_PRINT_INT_EN
            K_INT: begin
              if (dig_left) begin
                char_n = ascii_digit(conv_bcd[{dig_idx, 2'b00} +: 4]);
                if (dig_idx == 4'd0) dig_left_n = 1'b0;
                else                 dig_idx_n  = dig_idx - 4'd1;
              end else begin
                state_n = ST_DONE;
              end
            end
`endif
            default: state_n = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_n = ST_IDLE;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.mem_req    = (state == ST_STR_REQ);
  assign bus.mem_addr   = addr;
  assign bus.char_valid = (state == ST_EMIT);
  assign bus.char_data  = char_q;
  assign bus.sys_busy   = ((state == ST_IDLE) && bus.syscall_valid) ||
                          ((state != ST_IDLE) && (state != ST_DONE));
  assign bus.sys_done   = (state == ST_DONE);
  assign bus.halted     = (state == ST_HALT);
  assign bus.state      = state;

endmodule

// File: tb/tb_syscall_print_unit.sv
// Randomized scoreboard bench for syscall_print_unit: reference model pushes
// expected characters and read addresses, monitors pop and compare.
module tb_syscall_print_unit;
  import syscall_print_unit_pkg::*;

  localparam int MAX_STR_LEN = 256;

  logic clk = 1'b0;
  logic reset;

  syscall_print_unit_if #(.ADDR_W(32)) bus();

  syscall_print_unit #(.MAX_STR_LEN(MAX_STR_LEN), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic [7:0]  mem [0:4095];
  int          ready_mode;
  int          n_xfer;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_char(input logic [31:0] a0);
    exp_q.push_back(a0[7:0]);
  endtask

  task automatic model_str(input logic [31:0] a0);
    logic [31:0] a;
    logic [7:0]  b;
    for (int i = 0; i < MAX_STR_LEN; i++) begin
      a = a0 + 32'(i);
      addr_q.push_back(a);
      b = mem[a[11:0]];
      if (b == 8'h00) break;
      exp_q.push_back(b);
    end
  endtask

  task automatic model_int(input logic [31:0] a0);
    string s;
    s = $sformatf("%0d", $signed(a0));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // ---------------- memory, ready generator, monitors ----------------
  always @(posedge clk) begin
    if (bus.mem_req) bus.mem_rdata <= mem[bus.mem_addr[11:0]];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      bus.char_ready = 1'b1;
      else if (ready_mode == 1) bus.char_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e8;
    logic [31:0] e32;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("char_hold_valid", bus.char_valid, 1'b1);
          check("char_hold_data", bus.char_data, prev_data);
        end
        if (bus.char_valid && bus.char_ready) begin
          n_xfer++;
          check("char_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e8 = exp_q.pop_front();
            check("char_data", bus.char_data, e8);
          end
        end
        if (bus.mem_req) begin
          check("read_expected", addr_q.size() > 0, 1'b1);
          if (addr_q.size() > 0) begin
            e32 = addr_q.pop_front();
            check("read_addr", bus.mem_addr, e32);
          end
        end
        prev_stall = bus.char_valid && !bus.char_ready;
        prev_data  = bus.char_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
    @(posedge clk);
    #1;
    check("idle_busy_low", bus.sys_busy, 1'b0);
    bus.syscall_valid = 1'b1;
    bus.v0 = v0;
    bus.a0 = a0;
    #1;
    check("busy_on_accept", bus.sys_busy, 1'b1);
    @(posedge clk);
    #1;
    bus.syscall_valid = 1'b0;
  endtask

  // exp_lat < 0 skips the latency comparison (cycles counted from the accept cycle).
  task automatic wait_done(input string name, input int exp_lat);
    int  k;
    bit  seen;
    seen = 1'b0;
    for (k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (bus.sys_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      check({name, "_busy_in_done"}, bus.sys_busy, 1'b0);
      if (exp_lat >= 0) check({name, "_latency"}, k, exp_lat);
    end
    check({name, "_chars_left"}, exp_q.size(), 0);
    check({name, "_reads_left"}, addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_req"},    bus.mem_req, 1'b0);
    check({name, "_mem_addr"},   bus.mem_addr, 32'd0);
    check({name, "_char_valid"}, bus.char_valid, 1'b0);
    check({name, "_char_data"},  bus.char_data, 8'd0);
    check({name, "_sys_busy"},   bus.sys_busy, 1'b0);
    check({name, "_sys_done"},   bus.sys_done, 1'b0);
    check({name, "_halted"},     bus.halted, 1'b0);
    check({name, "_state"},      bus.state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a0;
    logic [31:0] v0;
    int          len;
    int          base;
    bit          found;
    bit          ok;
    bit          done_seen;
    string       s;

    reset = 1'b1;
    bus.syscall_valid = 1'b0;
    bus.v0 = '0;
    bus.a0 = '0;
    bus.char_ready = 1'b0;
    ready_mode = 2;
    n_xfer = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(1, 255));
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ready_mode = 0;
    bus.char_ready = 1'b1;

    // print_char, including a zero byte and junk in a0's upper bits
    model_char(32'h41);
    issue(SYS_PRINT_CHAR, 32'h41);
    wait_done("char_A", 2);
    model_char(32'hFFFF_FF00);
    issue(SYS_PRINT_CHAR, 32'hFFFF_FF00);
    wait_done("char_nul", 2);

    // "Hi" with the sink stalling three cycles on 'H'
    mem[12'h100] = 8'h48;
    mem[12'h101] = 8'h69;
    mem[12'h102] = 8'h00;
    ready_mode = 2;
    bus.char_ready = 1'b0;
    base = n_xfer;
    model_str(32'h100);
    issue(SYS_PRINT_STR, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.char_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("hi_first_char_seen", found, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.char_ready = 1'b1;
    ready_mode = 0;
    wait_done("str_hi", -1);
    check("str_hi_xfers", n_xfer - base, 2);

    // no terminator within MAX_STR_LEN bytes
    for (int i = 0; i < 300; i++) mem[12'h200 + i] = 8'($urandom_range(1, 255));
    model_str(32'h200);
    issue(SYS_PRINT_STR, 32'h200);
    wait_done("str_max", 3 * MAX_STR_LEN + 1);

    // address wrap across 2^32
    mem[12'hFFE] = 8'h61;
    mem[12'hFFF] = 8'h62;
    mem[12'h000] = 8'h63;
    mem[12'h001] = 8'h00;
    model_str(32'hFFFF_FFFE);
    issue(SYS_PRINT_STR, 32'hFFFF_FFFE);
    wait_done("str_wrap", 12);

    // random strings, alternating full-rate and random backpressure
    for (int t = 0; t < 8; t++) begin
      a0  = $urandom;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) mem[12'(a0 + 32'(i))] = 8'($urandom_range(1, 255));
      mem[12'(a0 + 32'(len))] = 8'h00;
      model_str(a0);
      if (t % 2 == 0) begin
        ready_mode = 0;
        bus.char_ready = 1'b1;
        issue(SYS_PRINT_STR, a0);
        wait_done($sformatf("str_rand%0d", t), 3 * len + 3);
      end else begin
        ready_mode = 1;
        issue(SYS_PRINT_STR, a0);
        wait_done($sformatf("str_rand%0d", t), -1);
      end
    end
    ready_mode = 0;
    bus.char_ready = 1'b1;

`ifdef SYSCALL_PRINT_INT_EN
    for (int t = 0; t < 8; t++) begin
      case (t)
        0: a0 = -32'sd305;
        1: a0 = 32'd0;
        2: a0 = 32'h8000_0000;
        3: a0 = 32'h7FFF_FFFF;
        4: a0 = 32'd7;
        default: a0 = $urandom;
      endcase
      s = $sformatf("%0d", $signed(a0));
      model_int(a0);
      issue(SYS_PRINT_INT, a0);
      wait_done($sformatf("int%0d", t), 33 + s.len());
    end
    ready_mode = 1;
    model_int(-32'sd90210);
    issue(SYS_PRINT_INT, -32'sd90210);
    wait_done("int_backpressure", -1);
    ready_mode = 0;
    bus.char_ready = 1'b1;
`else
    issue(SYS_PRINT_INT, -32'sd305);
    wait_done("int_disabled", 1);
`endif

    // unknown service codes produce no output
    for (int t = 0; t < 6; t++) begin
      if (t == 0) v0 = 32'h0000_0104;
      else if (t == 1) v0 = 32'h8000_000B;
      else begin
        do v0 = 32'($urandom_range(0, 40));
        while (v0 == 32'd1 || v0 == 32'd4 || v0 == 32'd10 || v0 == 32'd11);
      end
      issue(v0, $urandom);
      wait_done($sformatf("unknown%0d", t), 1);
    end

    // reset during the memory wait of the second byte
    mem[12'h300] = 8'h58;
    mem[12'h301] = 8'h59;
    mem[12'h302] = 8'h5A;
    mem[12'h303] = 8'h00;
    base = n_xfer;
    model_str(32'h300);
    issue(SYS_PRINT_STR, 32'h300);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.state == ST_STR_WAIT && n_xfer == base + 1) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_wait", found, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    check("abort_no_more_xfers", n_xfer - base, 1);
    model_char(32'h5A);
    issue(SYS_PRINT_CHAR, 32'h5A);
    wait_done("after_abort_char", 2);

    // exit halts until reset
    issue(SYS_EXIT, 32'd0);
    ok = 1'b1;
    done_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (!(bus.halted && bus.sys_busy)) ok = 1'b0;
      if (bus.sys_done) done_seen = 1'b1;
    end
    check("halt_held", ok, 1'b1);
    check("halt_no_done", done_seen, 1'b0);
    check("halt_state", bus.state, ST_HALT);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("halt_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syscall_print_unit.md
# syscall_print_unit

Services output system calls raised by the pipelined MIPS core: on an accepted syscall it reads the service code ($v0) and argument ($a0), then streams characters to a console sink over a valid/ready handshake. It walks data memory for `print_string`. It holds the pipeline through a busy signal that is OR-ed into the fetch/decode stall and execute flush. It sits beside the decode stage and answers the syscall stall raised there once $v0/$a0 are free of pending writes.

## Interface
- `MAX_STR_LEN`, 256: maximum bytes emitted per `print_string`, including when no NUL terminator is found.
- `ADDR_W`, 32: data-memory byte address width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `syscall_valid`  in  1  a syscall sits in decode with no syscall hazard pending.
- `v0`  in  32  service code, decode-stage register read.
- `a0`  in  32  argument, decode-stage register read.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  ADDR_W  byte address of the request.
- `mem_rdata`  in  8  read byte, valid the cycle after `mem_req`.
- `char_valid`  out  1  `char_data` holds a character.
- `char_data`  out  8  ASCII character.
- `char_ready`  in  1  sink accepts; transfer occurs when `char_valid && char_ready`.
- `sys_busy`  out  1  stall request to the pipeline (combinational).
- `sys_done`  out  1  one-cycle pulse; the syscall retires from decode.
- `halted`  out  1  the exit service ran; sticky until reset.

## Operation
- States: IDLE, STR_REQ, STR_WAIT, EMIT, INT_CONV (macro only), DONE, HALT.
- IDLE: `syscall_valid` latches `v0`/`a0` and dispatches on `v0`:
  - 11 (print_char): load `a0[7:0]` and go to EMIT. A value of 0 is still emitted.
  - 4 (print_string): set addr=`a0`, count=0, go to STR_REQ.
  - 10 (exit): go to HALT.
  - 1 (print_int): go to INT_CONV when the macro is defined. Otherwise it is treated as unknown.
  - any other code: go to DONE with no output.
- STR_REQ: `mem_req`=1, `mem_addr`=addr; next state STR_WAIT.
- STR_WAIT: if `mem_rdata`==0, go to DONE and emit nothing. Otherwise load the byte and go to EMIT.
- EMIT: `char_valid`=1 and `char_data` stable until the handshake completes. After the handshake:
  - print_char goes to DONE.
  - print_string: addr+1 (wraps modulo 2^ADDR_W), count+1. Go to DONE if count reaches `MAX_STR_LEN`, otherwise go to STR_REQ.
  - print_int: go to the next digit or to DONE.
- DONE: `sys_done`=1 for one cycle, `sys_busy`=0, `syscall_valid` ignored; next state IDLE.
- HALT: `halted`=1, `sys_busy`=1 permanently; only `reset` leaves this state.
- `sys_busy` = (IDLE && `syscall_valid`) || state ∉ {IDLE, DONE}.
- Reset values: state IDLE; `mem_req`, `char_valid`, `sys_busy`, `sys_done`, `halted` all 0; `mem_addr`, `char_data` 0. Reset mid-string abandons the transfer immediately with no further requests or characters.

## Timing
- `sys_busy` rises in the same cycle `syscall_valid` is seen in IDLE, so decode is held from the first cycle.
- print_char with `char_ready` held high: accept, EMIT, DONE, i.e. `sys_done` 2 cycles after acceptance.
- print_string: 3 cycles per byte with no backpressure (REQ, WAIT, EMIT). The NUL byte costs 2 cycles, then DONE.
- Memory read latency is fixed at 1 cycle; there is no memory-side stall.
- `char_valid` never drops without a handshake, and `char_data` never changes while `char_valid && !char_ready`.

## Configuration
- `SYSCALL_PRINT_INT_EN` defined: code 1 prints `a0` as signed decimal.
  - Negative values emit '-' first, then the magnitude taken as 32-bit unsigned, so -2147483648 prints correctly.
  - Leading zeros are suppressed; a value of 0 prints "0".
  - INT_CONV takes 32 cycles, then EMIT runs once per digit.
- Not defined: INT_CONV and the converter are absent, and code 1 takes the unknown-code path (DONE, no output).

## Structure
- Shared package/header `syscall_defs`: service codes SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11; state encoding; register numbers `v0`=2 and `a0`=4, the same values the hazard unit uses.
- Sub-module `bin2dec_serial`, instantiated only under the macro: iterative double-dabble, 32-bit in, 10 BCD digits out. Interface is `start`/`done`; `done` is asserted exactly 32 cycles after `start`.

## Test plan
- v0=11, a0=0x41, `char_ready`=1 → one 'A' transfer; `sys_done` 2 cycles after accept; `sys_busy` low in the DONE cycle.
- v0=4, a0=0x100, memory "Hi\0" at 0x100, `char_ready` low for 3 cycles on 'H' → 'H' then 'i', each held stable; reads at 0x100–0x102; no third character.
- v0=4 with no NUL in 300 bytes and `MAX_STR_LEN`=256 → exactly 256 characters, then `sys_done`.
- With the macro, v0=1, a0=-305 → '-','3','0','5'. a0=0 → '0'. Without the macro, v0=1 → no output and `sys_done`.
- v0=10 → `halted`=1 and `sys_busy`=1 held over 100 cycles; `reset` clears both.
- `reset` pulsed during the STR_WAIT of the second byte → all outputs 0 at once, state IDLE, and a new print_char afterwards completes normally.
